// File: rtl/tank_sprite_pkg.sv
// rtl/tank_sprite_pkg.sv - shared types and team palette table for the tank sprite pipeline
package tank_sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef logic [0:0] flash_state_t;
    localparam flash_state_t FLASH_IDLE   = 1'b0;
    localparam flash_state_t FLASH_ACTIVE = 1'b1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam int PALETTE_COUNT = 4;

    // Entry 0 of each palette is transparent and never shown.
    localparam rgb12_t PALETTE_TABLE [PALETTE_COUNT*4] = '{
        rgb12_t'(12'h000), rgb12_t'(12'hFC0), rgb12_t'(12'hA80), rgb12_t'(12'h640),
        rgb12_t'(12'h000), rgb12_t'(12'h0F0), rgb12_t'(12'h0A0), rgb12_t'(12'h050),
        rgb12_t'(12'h000), rgb12_t'(12'hFFF), rgb12_t'(12'hAAA), rgb12_t'(12'h666),
        rgb12_t'(12'h000), rgb12_t'(12'hF00), rgb12_t'(12'hA00), rgb12_t'(12'h500)
    };

    function automatic rgb12_t palette_lookup(input logic [1:0] pal, input logic [1:0] idx);
        return PALETTE_TABLE[{pal, idx}];
    endfunction

endpackage

// File: rtl/tank_sprite_unit_flash.sv
// rtl/tank_sprite_unit_flash.sv - frame-counted damage/spawn flash controller (tank_flash_ctrl)
module tank_flash_ctrl
    import tank_sprite_pkg::*;
#(
    parameter int FLASH_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       flash_req,
    input  logic [7:0] flash_frames,
    output logic       flashing,
    output logic       phase
);

    localparam int TW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

    flash_state_t  state;
    logic [7:0]    cnt;
    logic [TW-1:0] timer;

    // A request always wins over a same-cycle frame_start, so no decrement is lost or doubled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FLASH_IDLE;
            cnt   <= 8'd0;
            timer <= '0;
            phase <= 1'b0;
        end else if (flash_req) begin
            timer <= '0;
            if (flash_frames != 8'd0) begin
                state <= FLASH_ACTIVE;
                cnt   <= flash_frames;
                phase <= 1'b1;
            end else begin
                state <= FLASH_IDLE;
                cnt   <= 8'd0;
                phase <= 1'b0;
            end
        end else if (state == FLASH_ACTIVE && frame_start) begin
            if (cnt == 8'd1) begin
                state <= FLASH_IDLE;
                cnt   <= 8'd0;
                timer <= '0;
                phase <= 1'b0;
            end else begin
                cnt <= cnt - 8'd1;
                if (timer == TW'(FLASH_PERIOD - 1)) begin
                    timer <= '0;
                    phase <= ~phase;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

    assign flashing = (state == FLASH_ACTIVE);

endmodule

// File: rtl/tank_sprite_unit.sv
// rtl/tank_sprite_unit.sv - per-tank sprite pixel pipeline; TANK_SPRITE_ANIM_EN enables tread animation
module tank_sprite_unit
    import tank_sprite_pkg::*;
#(
    parameter int SPRITE_W      = 32,
    parameter int ROM_AW        = 10,
    parameter int ROM_LATENCY   = 1,
    parameter int N_PALETTES    = 4,
    parameter int FLASH_PALETTE = 2,
    parameter int FLASH_PERIOD  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic [9:0]                    draw_x,
    input  logic [9:0]                    draw_y,
    input  logic [9:0]                    tank_x,
    input  logic [9:0]                    tank_y,
    input  logic [1:0]                    dir,
    input  logic [$clog2(N_PALETTES)-1:0] palette_sel,
    input  logic                          moving,
    input  logic                          flash_req,
    input  logic [7:0]                    flash_frames,
    output logic [ROM_AW:0]               rom_addr,
    input  logic [1:0]                    rom_q,
    output logic [3:0]                    red,
    output logic [3:0]                    green,
    output logic [3:0]                    blue,
    output logic                          opaque,
    output logic                          out_valid,
    output logic                          flashing
);

    localparam int LW = $clog2(SPRITE_W);
    localparam int PW = $clog2(N_PALETTES);

    logic [9:0]    tank_x_s, tank_y_s;
    dir_t          dir_s;
    logic [PW-1:0] pal_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            tank_x_s <= '0;
            tank_y_s <= '0;
            dir_s    <= DIR_UP;
            pal_s    <= '0;
        end else if (frame_start) begin
            tank_x_s <= tank_x;
            tank_y_s <= tank_y;
            dir_s    <= dir_t'(dir);
            pal_s    <= palette_sel;
        end
    end

    logic anim;
`ifdef TANK_SPRITE_ANIM_EN
    logic       moving_s;
    logic [1:0] anim_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            moving_s <= 1'b0;
            anim     <= 1'b0;
            anim_cnt <= 2'd0;
        end else if (frame_start) begin
            moving_s <= moving;
            if (moving_s) begin
                if (anim_cnt == 2'd3) begin
                    anim_cnt <= 2'd0;
                    anim     <= ~anim;
                end else begin
                    anim_cnt <= anim_cnt + 2'd1;
                end
            end
        end
    end
`else
    logic unused_moving;
    assign unused_moving = moving;
    assign anim          = 1'b0;
`endif

    // Bit 10 of each difference is the borrow: the pixel lies left of / above the sprite.
    logic [10:0]   lx, ly;
    logic          inside_c;
    logic [LW-1:0] lxs, lys, src_r, src_c;

    assign lx       = {1'b0, draw_x} - {1'b0, tank_x_s};
    assign ly       = {1'b0, draw_y} - {1'b0, tank_y_s};
    assign inside_c = !lx[10] && !ly[10] && (lx[9:0] < 10'(SPRITE_W)) && (ly[9:0] < 10'(SPRITE_W));
    assign lxs      = lx[LW-1:0];
    assign lys      = ly[LW-1:0];

    // Inverting an LW-bit coordinate yields W-1-coordinate for free.
    always_comb begin
        src_r = lys;
        src_c = lxs;
        case (dir_s)
            DIR_UP:    begin src_r = lys;  src_c = lxs;  end
            DIR_RIGHT: begin src_r = ~lxs; src_c = lys;  end
            DIR_DOWN:  begin src_r = ~lys; src_c = ~lxs; end
            DIR_LEFT:  begin src_r = lxs;  src_c = ~lys; end
            default:   begin src_r = lys;  src_c = lxs;  end
        endcase
    end

    logic                   v0, in0;
    logic [ROM_LATENCY-1:0] v_pipe, in_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            v0       <= 1'b0;
            in0      <= 1'b0;
            rom_addr <= '0;
            v_pipe   <= '0;
            in_pipe  <= '0;
        end else begin
            v0       <= pix_valid;
            in0      <= pix_valid && inside_c;
            rom_addr <= inside_c ? {anim, ROM_AW'({src_r, src_c})} : '0;
            v_pipe[0]  <= v0;
            in_pipe[0] <= in0;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                v_pipe[i]  <= v_pipe[i-1];
                in_pipe[i] <= in_pipe[i-1];
            end
        end
    end

    logic flash_phase;

    tank_flash_ctrl #(
        .FLASH_PERIOD(FLASH_PERIOD)
    ) u_flash (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .flash_req   (flash_req),
        .flash_frames(flash_frames),
        .flashing    (flashing),
        .phase       (flash_phase)
    );

    logic [PW-1:0] pal_eff;
    rgb12_t        rgb_c;
    logic          opaque_c;

    assign pal_eff  = (flashing && flash_phase) ? PW'(FLASH_PALETTE) : pal_s;
    assign rgb_c    = palette_lookup(2'(pal_eff), rom_q);
    assign opaque_c = v_pipe[ROM_LATENCY-1] && in_pipe[ROM_LATENCY-1] && (rom_q != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            opaque    <= 1'b0;
            red       <= 4'd0;
            green     <= 4'd0;
            blue      <= 4'd0;
        end else begin
            out_valid <= v_pipe[ROM_LATENCY-1];
            opaque    <= opaque_c;
            red       <= opaque_c ? rgb_c.r : 4'd0;
            green     <= opaque_c ? rgb_c.g : 4'd0;
            blue      <= opaque_c ? rgb_c.b : 4'd0;
        end
    end

endmodule

// File: tb/tb_tank_sprite_unit.sv
// tb/tb_tank_sprite_unit.sv - directed self-checking bench for tank_sprite_unit
module tb_tank_sprite_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  draw_x, draw_y, tank_x, tank_y;
    logic [1:0]  dir;
    logic [1:0]  palette_sel;
    logic        moving;
    logic        flash_req;
    logic [7:0]  flash_frames;
    logic [10:0] rom_addr;
    logic [1:0]  rom_q;
    logic [3:0]  red, green, blue;
    logic        opaque, out_valid, flashing;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Sprite ROM model: palette index is the low two address bits, one cycle latency.
    always @(posedge clk) rom_q <= rom_addr[1:0];

    tank_sprite_unit dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .tank_x      (tank_x),
        .tank_y      (tank_y),
        .dir         (dir),
        .palette_sel (palette_sel),
        .moving      (moving),
        .flash_req   (flash_req),
        .flash_frames(flash_frames),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .opaque      (opaque),
        .out_valid   (out_valid),
        .flashing    (flashing)
    );

    task automatic frame_pulse();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic latch(input logic [9:0] tx, input logic [9:0] ty, input logic [1:0] d, input logic [1:0] p);
        tank_x = tx; tank_y = ty; dir = d; palette_sel = p;
        frame_pulse();
    endtask

    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, output logic [10:0] a,
                             output logic early, output logic v, output logic o, output logic [11:0] c);
        draw_x = x; draw_y = y; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        a = rom_addr;
        @(negedge clk);
        early = out_valid;
        @(negedge clk);
        v = out_valid; o = opaque; c = {red, green, blue};
    endtask

    task automatic test_reset();
        reset = 1'b1; pix_valid = 1'b1; draw_x = 10'd0; draw_y = 10'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, red, green, blue, rom_addr, flashing} !== 24'd0) begin
            errors++;
            $display("FAIL reset_during got ov=%b rgb=%h addr=%0d fl=%b want all 0", out_valid, {red, green, blue}, rom_addr, flashing);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, red, green, blue, rom_addr, flashing} !== 24'd0) begin
            errors++;
            $display("FAIL reset_after got ov=%b rgb=%h addr=%0d fl=%b want all 0", out_valid, {red, green, blue}, rom_addr, flashing);
        end
        pix_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_directions();
        logic [10:0] a; logic e, v, o; logic [11:0] c;
        logic [10:0] exp_a [4] = '{11'd101, 11'd835, 11'd922, 11'd188};
        logic [11:0] exp_c [4] = '{12'hFC0, 12'h640, 12'hA80, 12'h000};
        for (int d = 0; d < 4; d++) begin
            latch(10'd100, 10'd50, 2'(d), 2'd0);
            run_pixel(10'd105, 10'd53, a, e, v, o, c);
            checks++;
            if (a !== exp_a[d]) begin errors++; $display("FAIL dir%0d_addr got %0d want %0d", d, a, exp_a[d]); end
            checks++;
            if (e !== 1'b0 || v !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got early=%b final=%b want 0 1", d, e, v); end
            checks++;
            if (o !== (d != 3) || c !== exp_c[d]) begin
                errors++; $display("FAIL dir%0d_pixel got opq=%b rgb=%h want %b %h", d, o, c, d != 3, exp_c[d]);
            end
        end
    endtask

    task automatic test_outside();
        logic [10:0] a; logic e, v, o; logic [11:0] c;
        logic [9:0] xs [2] = '{10'd99, 10'd132};
        latch(10'd100, 10'd50, 2'd0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            run_pixel(xs[i], 10'd50, a, e, v, o, c);
            checks++;
            if (a !== 11'd0 || v !== 1'b1 || o !== 1'b0 || c !== 12'h000) begin
                errors++; $display("FAIL outside_x%0d got addr=%0d ov=%b opq=%b rgb=%h want 0 1 0 000", xs[i], a, v, o, c);
            end
        end
    endtask

    task automatic test_palette_shadow();
        logic [10:0] a; logic e, v, o; logic [11:0] c;
        palette_sel = 2'd1;
        run_pixel(10'd105, 10'd53, a, e, v, o, c);
        checks++;
        if (c !== 12'hFC0) begin errors++; $display("FAIL pal_midframe got %h want FC0", c); end
        frame_pulse();
        run_pixel(10'd105, 10'd53, a, e, v, o, c);
        checks++;
        if (c !== 12'h0F0) begin errors++; $display("FAIL pal_newframe got %h want 0F0", c); end
    endtask

    task automatic test_flash();
        logic [10:0] a; logic e, v, o; logic [11:0] c;
        flash_frames = 8'd8; flash_req = 1'b1;
        @(negedge clk);
        flash_req = 1'b0;
        checks++;
        if (flashing !== 1'b1) begin errors++; $display("FAIL flash_start got %b want 1", flashing); end
        run_pixel(10'd105, 10'd53, a, e, v, o, c);
        checks++;
        if (c !== 12'hFFF) begin errors++; $display("FAIL flash_frame1 got %h want FFF", c); end
        repeat (3) frame_pulse();
        run_pixel(10'd105, 10'd53, a, e, v, o, c);
        checks++;
        if (c !== 12'hFFF || flashing !== 1'b1) begin errors++; $display("FAIL flash_frame4 got %h fl=%b want FFF 1", c, flashing); end
        frame_pulse();
        run_pixel(10'd105, 10'd53, a, e, v, o, c);
        checks++;
        if (c !== 12'h0F0 || flashing !== 1'b1) begin errors++; $display("FAIL flash_frame5 got %h fl=%b want 0F0 1", c, flashing); end
        repeat (3) frame_pulse();
        checks++;
        if (flashing !== 1'b1) begin errors++; $display("FAIL flash_frame8 got %b want 1", flashing); end
        frame_pulse();
        checks++;
        if (flashing !== 1'b0) begin errors++; $display("FAIL flash_end got %b want 0", flashing); end
    endtask

    task automatic test_flash_same_cycle();
        frame_start = 1'b1; flash_req = 1'b1; flash_frames = 8'd8;
        @(negedge clk);
        frame_start = 1'b0; flash_req = 1'b0;
        repeat (7) frame_pulse();
        checks++;
        if (flashing !== 1'b1) begin errors++; $display("FAIL same_cycle_7 got %b want 1", flashing); end
        frame_pulse();
        checks++;
        if (flashing !== 1'b0) begin errors++; $display("FAIL same_cycle_8 got %b want 0", flashing); end
        flash_frames = 8'd5; flash_req = 1'b1;
        @(negedge clk);
        flash_frames = 8'd0;
        @(negedge clk);
        flash_req = 1'b0;
        checks++;
        if (flashing !== 1'b0) begin errors++; $display("FAIL zero_frames_cancel got %b want 0", flashing); end
    endtask

    task automatic test_reset_flush();
        flash_frames = 8'd8; flash_req = 1'b1;
        @(negedge clk);
        flash_req = 1'b0;
        draw_x = 10'd105; draw_y = 10'd53; pix_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || flashing !== 1'b0) begin errors++; $display("FAIL flush_during got ov=%b fl=%b want 0 0", out_valid, flashing); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || rom_addr !== 11'd0) begin errors++; $display("FAIL flush_after1 got ov=%b addr=%0d want 0 0", out_valid, rom_addr); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after2 got %b want 0", out_valid); end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || opaque !== 1'b0) begin errors++; $display("FAIL flush_refill got ov=%b opq=%b want 1 0", out_valid, opaque); end
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        draw_x = '0; draw_y = '0; tank_x = '0; tank_y = '0; dir = '0; palette_sel = '0;
        moving = 1'b0; flash_req = 1'b0; flash_frames = '0;
        @(negedge clk);
        test_reset();
        test_directions();
        test_outside();
        test_palette_shadow();
        test_flash();
        test_flash_same_cycle();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
